dl_rshift_pipe: RTL and testbench

DL_RSHIFT_PIPE -- requirements
Module: dl_rshift_pipe

---
 rtl/dl_rshift_pipe.sv | 103 ++++++++++
 tb/tb_dl_rshift_pipe.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dl_rshift_pipe.sv
// Pipelined barrel right shifter, one power-of-two shift step per stage.
// Valid/ready handshake at both ends; stalls compress bubbles.
module dl_rshift_pipe #(
  parameter int NUM_BITS       = 32,
  parameter int NUM_SHIFT_BITS = $clog2(NUM_BITS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_BITS-1:0]       a,
  input  logic [NUM_SHIFT_BITS-1:0] shift,
  input  logic                      arith,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_BITS-1:0]       out
);

  localparam int W = NUM_BITS;
  localparam int S = NUM_SHIFT_BITS;

  logic [S-1:0]         vld_q;
  logic [S-1:0][W-1:0]  dat_q;
  logic [S-1:0][S-1:0]  sh_q;
  logic [S-1:0]         ar_q;

  logic [S-1:0]         adv;
  logic [S-1:0]         load;
  logic [S-1:0][W-1:0]  din;
  logic [S-1:0][S-1:0]  sh_in;
  logic [S-1:0]         ar_in;
  logic [S-1:0][W-1:0]  dat_d;

  always_comb begin
    adv        = '0;
    adv[S-1]   = vld_q[S-1] & out_ready;
    for (int k = S - 2; k >= 0; k--) begin
      adv[k] = vld_q[k] & (~vld_q[k+1] | adv[k+1]);
    end
  end

  assign in_ready = ~vld_q[0] | adv[0];

  always_comb begin
    load     = '0;
    din      = '0;
    sh_in    = '0;
    ar_in    = '0;
    load[0]  = in_valid & in_ready;
    din[0]   = a;
    sh_in[0] = shift;
    ar_in[0] = arith;
    for (int k = 1; k < S; k++) begin
      load[k]  = adv[k-1];
      din[k]   = dat_q[k-1];
      sh_in[k] = sh_q[k-1];
      ar_in[k] = ar_q[k-1];
    end
  end

  // Arithmetic steps keep the MSB, so each stage's MSB is the original sign.
  always_comb begin
    dat_d = '0;
    for (int k = 0; k < S; k++) begin
      if (sh_in[k][k]) begin
        dat_d[k] = din[k] >> (1 << k);
        if (ar_in[k] && din[k][W-1]) begin
          dat_d[k] = dat_d[k] | ~({W{1'b1}} >> (1 << k));
        end
      end else begin
        dat_d[k] = din[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      dat_q <= '0;
      sh_q  <= '0;
      ar_q  <= '0;
    end else begin
      for (int k = 0; k < S; k++) begin
        if (load[k]) begin
          vld_q[k] <= 1'b1;
          dat_q[k] <= dat_d[k];
          sh_q[k]  <= sh_in[k];
          ar_q[k]  <= ar_in[k];
        end else if (adv[k]) begin
          vld_q[k] <= 1'b0;
        end
      end
    end
  end

  assign out_valid = vld_q[S-1];
  assign out       = dat_q[S-1];

  // Shift bits already consumed and the last stage's control are dead.
  logic unused_ctl;
  assign unused_ctl = ^{sh_q, ar_q[S-1]};

endmodule

// File: tb/tb_dl_rshift_pipe.sv
// Directed-vector and scoreboard bench for dl_rshift_pipe.
// Default 32-bit width, five stages.
module tb_dl_rshift_pipe;

  localparam int W = 32;
  localparam int S = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [S-1:0] shift = '0;
  logic         arith = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out;

  dl_rshift_pipe dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .shift(shift),
    .arith(arith),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out(out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [S-1:0] sh;
    logic         ar;
    logic [W-1:0] exp;
  } vec_t;

  vec_t         vecs[15];
  logic [W-1:0] q[$];
  int           dcyc[$];
  int           checks = 0;
  int           errors = 0;
  int           cycle = 0;
  int           n_acc = 0;
  int           n_drn = 0;

  function automatic logic [W-1:0] model(
    logic [W-1:0] x, logic [S-1:0] s, logic ar);
    if (ar) return W'($signed(x) >>> s);
    return x >> s;
  endfunction

  task automatic check(string name, logic [W-1:0] act,
                       logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(output bit acc);
    bit drn;
    #1;
    acc = in_valid && in_ready;
    drn = out_valid && out_ready;
    if (drn) begin
      n_drn++;
      dcyc.push_back(cycle);
      if (q.size() == 0) check("extra_out", out, 'x);
      else check("drain", out, q.pop_front());
    end
    if (acc) begin
      n_acc++;
      q.push_back(model(a, shift, arith));
    end
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic send(vec_t v);
    bit acc;
    int n;
    a = v.a; shift = v.sh; arith = v.ar;
    in_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 20) begin
      cyc(acc);
      n++;
    end
    in_valid = 1'b0;
    if (!acc) check("accept_timeout", 0, 1);
    else if (q[q.size()-1] !== v.exp)
      check("model_vs_table", q[q.size()-1], v.exp);
  endtask

  task automatic drain_all();
    bit acc;
    int n;
    out_ready = 1'b1;
    in_valid = 1'b0;
    n = 0;
    while (q.size() > 0 && n < 200) begin
      cyc(acc);
      n++;
    end
    check("drain_done", W'(q.size()), 0);
  endtask

  initial begin
    bit acc;
    int lat, cnt;
    logic [W-1:0] hold;
    bit stable, seen;
    vecs[0]  = '{32'h80000000, 5'd31, 1'b1, 32'hFFFFFFFF};
    vecs[1]  = '{32'h80000000, 5'd31, 1'b0, 32'h00000001};
    vecs[2]  = '{32'h12345678, 5'd0,  1'b0, 32'h12345678};
    vecs[3]  = '{32'h12345678, 5'd0,  1'b1, 32'h12345678};
    vecs[4]  = '{32'hF0F0F0F0, 5'd4,  1'b1, 32'hFF0F0F0F};
    vecs[5]  = '{32'hF0F0F0F0, 5'd4,  1'b0, 32'h0F0F0F0F};
    vecs[6]  = '{32'h7FFFFFFF, 5'd31, 1'b1, 32'h00000000};
    vecs[7]  = '{32'h7FFFFFFF, 5'd1,  1'b1, 32'h3FFFFFFF};
    vecs[8]  = '{32'h80000001, 5'd1,  1'b1, 32'hC0000000};
    vecs[9]  = '{32'hDEADBEEF, 5'd16, 1'b0, 32'h0000DEAD};
    vecs[10] = '{32'hDEADBEEF, 5'd16, 1'b1, 32'hFFFFDEAD};
    vecs[11] = '{32'h89ABCDEF, 5'd8,  1'b1, 32'hFF89ABCD};
    vecs[12] = '{32'h89ABCDEF, 5'd7,  1'b0, 32'h0113579B};
    vecs[13] = '{32'h00000001, 5'd31, 1'b1, 32'h00000000};
    vecs[14] = '{32'hFFFFFFFF, 5'd5,  1'b0, 32'h07FFFFFF};

    #1;
    check("rst_out_valid", W'(out_valid), 0);
    check("rst_out", out, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", W'(in_ready), 1);

    // Latency of the first op after reset
    out_ready = 1'b1;
    send(vecs[0]);
    lat = 0;
    while (!out_valid && lat < 20) begin
      cyc(acc);
      lat++;
    end
    check("latency", W'(lat), 4);
    drain_all();

    for (int i = 1; i < 15; i++) begin
      send(vecs[i]);
      drain_all();
    end

    // Back-to-back stream
    dcyc.delete();
    for (int i = 0; i < 8; i++) begin
      a = W'(i) << 28;
      shift = S'(i);
      arith = i[0];
      in_valid = 1'b1;
      cyc(acc);
      check("b2b_in_ready", W'(acc), 1);
    end
    drain_all();
    check("b2b_count", W'(dcyc.size()), 8);
    if (dcyc.size() == 8)
      check("b2b_consecutive", W'(dcyc[7] - dcyc[0]), 7);

    // Backpressure fill
    out_ready = 1'b0;
    cnt = 0;
    stable = 1'b1;
    seen = 1'b0;
    hold = '0;
    for (int i = 0; i < 10; i++) begin
      a = 32'hA5000000 | W'(i);
      shift = S'(i + 3);
      arith = 1'b1;
      in_valid = 1'b1;
      cyc(acc);
      if (acc) cnt++;
      if (out_valid && !seen) begin
        seen = 1'b1;
        hold = out;
      end else if (seen && out !== hold) begin
        stable = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("bp_accepts", W'(cnt), 5);
    check("bp_in_ready_low", W'(in_ready), 0);
    check("bp_out_stable", W'(stable && seen), 1);
    drain_all();

    // Reset mid-flight
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 32'h13570000 + W'(i);
      shift = S'(i);
      arith = 1'b0;
      in_valid = 1'b1;
      cyc(acc);
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", W'(out_valid), 0);
    check("mid_rst_out", out, 0);
    q.delete();
    #2 rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", W'(in_ready), 1);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) seen = 1'b1;
      cyc(acc);
    end
    check("no_stale", W'(seen), 0);
    send('{32'hF0F0F0F0, 5'd4, 1'b1, 32'hFF0F0F0F});
    drain_all();

    // Random traffic against the queue model
    n_acc = 0;
    n_drn = 0;
    for (int i = 0; i < 10000; i++) begin
      a = $urandom;
      shift = S'($urandom_range(0, W - 1));
      arith = 1'($urandom_range(0, 1));
      in_valid = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      cyc(acc);
    end
    drain_all();
    check("rand_balance", W'(n_acc), W'(n_drn));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
